// File: rtl/bcd_conv_arbiter_pkg.sv
// Shared types and constants for the two-requester BCD-to-binary converter.
package bcd_conv_arbiter_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned BIN_W   = 7;
  localparam int unsigned CNT_W   = 8;

  localparam logic [BIN_W-1:0] MAX_BIN = 7'd99;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic               id;
    logic [DIGIT_W-1:0] ten;
    logic [DIGIT_W-1:0] one;
  } operand_t;

endpackage

// File: rtl/bcd2bin_core.sv
// Combinational two-digit BCD to binary conversion with digit range check.
module bcd2bin_core
  import bcd_conv_arbiter_pkg::*;
(
  input  logic [DIGIT_W-1:0] ONE,
  input  logic [DIGIT_W-1:0] TEN,
  output logic [BIN_W-1:0]   BIN,
  output logic               ERR
);

  logic [BIN_W-1:0] sum;

  always_comb begin
    sum = BIN_W'(TEN) * 7'd10 + BIN_W'(ONE);
    ERR = (ONE > 4'd9) || (TEN > 4'd9) || (sum > MAX_BIN);
    BIN = ERR ? '0 : sum;
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter for two BCD operand requesters feeding one converter.
module bcd_conv_arbiter
  import bcd_conv_arbiter_pkg::*;
#(
  parameter logic [BIN_W-1:0] ERR_BIN = 7'd0
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               REQ0_VALID,
  input  logic [DIGIT_W-1:0] REQ0_ONE,
  input  logic [DIGIT_W-1:0] REQ0_TEN,
  output logic               REQ0_READY,
  input  logic               REQ1_VALID,
  input  logic [DIGIT_W-1:0] REQ1_ONE,
  input  logic [DIGIT_W-1:0] REQ1_TEN,
  output logic               REQ1_READY,
  output logic               RSP_VALID,
  output logic [BIN_W-1:0]   RSP_BIN,
  output logic               RSP_ERR,
  output logic               RSP_ID,
  input  logic               RSP_READY,
  output logic [CNT_W-1:0]   DONE_CNT
);

  state_e            state_q, state_d;
  operand_t          op_q, op_d;
  logic              last_q, last_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic              err_q, err_d;
  logic              id_q, id_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              gnt, gnt_valid;
  logic              ready0_c, ready1_c;
  logic [BIN_W-1:0]  core_bin;
  logic              core_err;

  bcd2bin_core u_core (
    .ONE (op_q.one),
    .TEN (op_q.ten),
    .BIN (core_bin),
    .ERR (core_err)
  );

  // Under contention the requester not served last wins.
  always_comb begin
    if (REQ0_VALID && REQ1_VALID) gnt = ~last_q;
    else                          gnt = REQ1_VALID;
    gnt_valid = gnt ? REQ1_VALID : REQ0_VALID;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    last_d   = last_q;
    bin_d    = bin_q;
    err_d    = err_q;
    id_d     = id_q;
    cnt_d    = cnt_q;
    ready0_c = 1'b0;
    ready1_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          ready0_c = ~gnt;
          ready1_c = gnt;
          op_d.id  = gnt;
          op_d.one = gnt ? REQ1_ONE : REQ0_ONE;
          op_d.ten = gnt ? REQ1_TEN : REQ0_TEN;
          last_d   = gnt;
          state_d  = CONV;
        end
      end
      CONV: begin
        bin_d   = core_err ? ERR_BIN : core_bin;
        err_d   = core_err;
        id_d    = op_q.id;
        state_d = RESP;
      end
      RESP: begin
        if (RSP_READY) begin
          cnt_d   = cnt_q + 8'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // No handshake may be advertised while the register bank is being reset.
    if (RST) begin
      ready0_c = 1'b0;
      ready1_c = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      op_q    <= '0;
      last_q  <= 1'b1;
      bin_q   <= '0;
      err_q   <= 1'b0;
      id_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      last_q  <= last_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
    end
  end

  assign REQ0_READY = ready0_c;
  assign REQ1_READY = ready1_c;
  assign RSP_VALID  = (state_q == RESP);
  assign RSP_BIN    = bin_q;
  assign RSP_ERR    = err_q;
  assign RSP_ID     = id_q;
  assign DONE_CNT   = cnt_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed self-checking bench for bcd_conv_arbiter.
module tb_bcd_conv_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0] req0_one, req0_ten, req1_one, req1_ten;
  logic       rsp_valid, rsp_err, rsp_id, rsp_ready;
  logic [6:0] rsp_bin;
  logic [7:0] done_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bcd_conv_arbiter #(.ERR_BIN(7'd77)) dut (
    .CLK        (clk),
    .RST        (rst),
    .REQ0_VALID (req0_valid),
    .REQ0_ONE   (req0_one),
    .REQ0_TEN   (req0_ten),
    .REQ0_READY (req0_ready),
    .REQ1_VALID (req1_valid),
    .REQ1_ONE   (req1_one),
    .REQ1_TEN   (req1_ten),
    .REQ1_READY (req1_ready),
    .RSP_VALID  (rsp_valid),
    .RSP_BIN    (rsp_bin),
    .RSP_ERR    (rsp_err),
    .RSP_ID     (rsp_id),
    .RSP_READY  (rsp_ready),
    .DONE_CNT   (done_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rsp(input string tag, input logic v, input logic [6:0] bin,
                           input logic err, input logic id);
    check_eq({tag, "_valid"}, 32'(rsp_valid), 32'(v));
    check_eq({tag, "_bin"},   32'(rsp_bin),   32'(bin));
    check_eq({tag, "_err"},   32'(rsp_err),   32'(err));
    check_eq({tag, "_id"},    32'(rsp_id),    32'(id));
  endtask

  // Expects to be entered in IDLE with the requester's VALID already driven.
  task automatic run_txn(input string tag, input logic exp_id, input logic [6:0] exp_bin,
                         input logic exp_err, input logic [7:0] exp_cnt);
    #1;
    check_eq({tag, "_rdy0"}, 32'(req0_ready), 32'(!exp_id));
    check_eq({tag, "_rdy1"}, 32'(req1_ready), 32'(exp_id));
    tick();
    if (exp_id) req1_valid = 1'b0;
    else        req0_valid = 1'b0;
    #1;
    check_eq({tag, "_conv_valid"}, 32'(rsp_valid), 32'd0);
    check_eq({tag, "_conv_rdy"},   32'({req0_ready, req1_ready}), 32'd0);
    tick();
    check_rsp({tag, "_resp"}, 1'b1, exp_bin, exp_err, exp_id);
    tick();
    check_eq({tag, "_idle_valid"}, 32'(rsp_valid), 32'd0);
    check_eq({tag, "_cnt"},        32'(done_cnt),  32'(exp_cnt));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_one = 4'd0; req0_ten = 4'd0;
    req1_valid = 1'b0; req1_one = 4'd0; req1_ten = 4'd0;
    repeat (2) tick();
    check_rsp("reset", 1'b0, 7'd0, 1'b0, 1'b0);
    check_eq("reset_cnt",  32'(done_cnt),   32'd0);
    check_eq("reset_rdy0", 32'(req0_ready), 32'd0);
    check_eq("reset_rdy1", 32'(req1_ready), 32'd0);
    req0_valid = 1'b0;
    rst = 1'b0;
    tick();

    // Basic conversion and error path.
    req0_one = 4'd2; req0_ten = 4'd4; req0_valid = 1'b1;
    run_txn("t42", 1'b0, 7'd42, 1'b0, 8'd1);
    req1_one = 4'hA; req1_ten = 4'd3; req1_valid = 1'b1;
    run_txn("terr", 1'b1, 7'd77, 1'b1, 8'd2);

    // Consumer stall; requester 1 comes and goes without being served.
    rsp_ready = 1'b0;
    req0_one = 4'd1; req0_ten = 4'd2; req0_valid = 1'b1;
    #1;
    check_eq("stall_rdy0", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    req1_one = 4'd5; req1_ten = 4'd5; req1_valid = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      check_rsp("stall_hold", 1'b1, 7'd21, 1'b0, 1'b0);
      check_eq("stall_rdy", 32'({req0_ready, req1_ready}), 32'd0);
      check_eq("stall_cnt", 32'(done_cnt), 32'd2);
      tick();
    end
    check_eq("stall_still", 32'(rsp_valid), 32'd1);
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    tick();
    check_eq("stall_done_valid", 32'(rsp_valid), 32'd0);
    check_eq("stall_done_cnt",   32'(done_cnt),  32'd3);
    tick();
    check_eq("drop_no_xfer", 32'(rsp_valid), 32'd0);
    check_eq("drop_cnt",     32'(done_cnt),  32'd3);

    // Pointer still says requester 0 was last, so requester 1 wins now.
    req0_one = 4'd1; req0_ten = 4'd1; req0_valid = 1'b1;
    req1_one = 4'd9; req1_ten = 4'd0; req1_valid = 1'b1;
    run_txn("rr_a", 1'b1, 7'd9,  1'b0, 8'd4);
    run_txn("rr_b", 1'b0, 7'd11, 1'b0, 8'd5);

    // Reset while converting.
    req0_one = 4'd7; req0_ten = 4'd1; req0_valid = 1'b1;
    #1;
    check_eq("rconv_rdy0", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    rst = 1'b1;
    tick();
    check_eq("rconv_valid", 32'(rsp_valid), 32'd0);
    check_eq("rconv_cnt",   32'(done_cnt),  32'd0);
    rst = 1'b0;
    tick();
    check_eq("rconv_discard", 32'(rsp_valid), 32'd0);
    req0_one = 4'd5; req0_ten = 4'd2; req0_valid = 1'b1;
    run_txn("rconv_after", 1'b0, 7'd25, 1'b0, 8'd1);

    // Reset while presenting a response.
    rsp_ready = 1'b0;
    req0_one = 4'd8; req0_ten = 4'd8; req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    tick();
    check_rsp("rresp_pre", 1'b1, 7'd88, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    check_rsp("rresp", 1'b0, 7'd0, 1'b0, 1'b0);
    check_eq("rresp_cnt", 32'(done_cnt), 32'd0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    tick();
    check_eq("rresp_idle", 32'(rsp_valid), 32'd0);
    req0_one = 4'd3; req0_ten = 4'd6; req0_valid = 1'b1;
    run_txn("rresp_after", 1'b0, 7'd63, 1'b0, 8'd1);

    // Contention straight after reset favours requester 0, then alternates.
    pulse_reset();
    req0_one = 4'd9; req0_ten = 4'd9; req0_valid = 1'b1;
    req1_one = 4'd0; req1_ten = 4'd1; req1_valid = 1'b1;
    run_txn("cont_1", 1'b0, 7'd99, 1'b0, 8'd1);
    run_txn("cont_2", 1'b1, 7'd10, 1'b0, 8'd2);
    req0_one = 4'd5; req0_ten = 4'd7; req0_valid = 1'b1;
    req1_one = 4'd8; req1_ten = 4'd0; req1_valid = 1'b1;
    run_txn("cont_3", 1'b0, 7'd75, 1'b0, 8'd3);
    run_txn("cont_4", 1'b1, 7'd8,  1'b0, 8'd4);

    // 256 completions wrap the counter.
    pulse_reset();
    req0_one = 4'd0; req0_ten = 4'd0; req0_valid = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 1000 && n < 255; cyc++) begin
      tick();
      if (rsp_valid) n++;
    end
    check_eq("wrap_count", 32'(n), 32'd255);
    req0_valid = 1'b0;
    tick();
    check_eq("wrap_255", 32'(done_cnt), 32'd255);
    req0_valid = 1'b1;
    run_txn("wrap_0", 1'b0, 7'd0, 1'b0, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_conv_arbiter.md
BCD_CONV_ARBITER -- requirements
Module: bcd_conv_arbiter

Interface
REQ-001 Parameter ERR_BIN, default 7'd0: value driven on RSP_BIN for a rejected (non-BCD) request.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  reset; synchronous, active-high.
REQ-004 REQ0_VALID  input  1  requester 0 holds an operand pair.
REQ-005 REQ0_ONE / REQ0_TEN  input  4 each  requester 0 BCD units / tens digit.
REQ-006 REQ0_READY  output  1  requester 0 operand accepted this cycle.
REQ-007 REQ1_VALID, REQ1_ONE, REQ1_TEN, REQ1_READY  same widths and meaning for requester 1.
REQ-008 RSP_VALID  output  1  result held on RSP_* outputs.
REQ-009 RSP_BIN  output  7  binary value, 0..99.
REQ-010 RSP_ERR  output  1  accepted digit was greater than 9.
REQ-011 RSP_ID  output  1  requester index owning the response.
REQ-012 RSP_READY  input  1  consumer takes the response.
REQ-013 DONE_CNT  output  8  count of completed responses; wraps 255->0.

Function
REQ-014 The FSM SHALL have states IDLE, CONV and RESP.
REQ-015 In IDLE, a transfer SHALL occur when the granted requester has VALID=1; its READY SHALL be 1 in that cycle only; the FSM SHALL then go to CONV.
REQ-016 READY SHALL be 0 in CONV and RESP, and SHALL be 0 for the non-granted requester.
REQ-017 At a transfer, ONE, TEN and the requester index SHALL be captured into an operand register.
REQ-018 Grant with one requester valid: that requester.
REQ-019 Grant with both valid: the requester not granted last (round-robin); the last-grant pointer SHALL update only on a transfer.
REQ-020 CONV SHALL compute BIN = 10*TEN + ONE from the captured operand, register it with ERR and ID, and go to RESP after exactly one cycle.
REQ-021 If ONE>9 or TEN>9, RSP_ERR SHALL be 1 and RSP_BIN SHALL be ERR_BIN; otherwise RSP_ERR SHALL be 0.
REQ-022 In RESP, RSP_VALID SHALL be 1 and RSP_BIN, RSP_ERR and RSP_ID SHALL be stable until RSP_READY=1.
REQ-023 When RSP_VALID=1 and RSP_READY=1, the FSM SHALL return to IDLE and DONE_CNT SHALL increment, including for errored requests.
REQ-024 Latency: transfer at cycle N gives RSP_VALID=1 first at N+2; with RSP_READY held high, the next transfer SHALL occur no earlier than N+3.
REQ-025 RSP_VALID SHALL be 0 in IDLE and CONV; RSP_* data outside RESP is don't-care but SHALL NOT be X after reset.
REQ-026 A requester dropping VALID before a transfer SHALL NOT be granted and SHALL NOT leave any state change.

Reset
REQ-027 With RST=1 at a clock edge, the FSM SHALL enter IDLE, including from CONV or RESP; any in-flight operation SHALL be discarded.
REQ-028 Reset values: RSP_VALID=0, RSP_BIN=0, RSP_ERR=0, RSP_ID=0, DONE_CNT=0, both READY=0.
REQ-029 Reset SHALL set the last-grant pointer to 1, so requester 0 wins the first contention.

Structure
REQ-030 State encodings and the constant 7'd99 (max valid result) SHALL live in a shared package.
REQ-031 The combinational conversion SHALL be one sub-module, bcd2bin_core, with inputs ONE[3:0] and TEN[3:0] and outputs BIN[6:0] and ERR; the arbiter instantiates it once on the operand register.

Verification
REQ-032 REQ0 ONE=2, TEN=4, RSP_READY=1, transfer at N -> RSP_VALID at N+2, RSP_BIN=42, RSP_ERR=0, RSP_ID=0, DONE_CNT=1.
REQ-033 Both VALID after reset with operands 9,9 and 0,1 -> REQ0 served first (RSP_BIN=99), then REQ1 (RSP_BIN=10, RSP_ID=1); a third contention grants REQ0.
REQ-034 REQ1 ONE=4'hA, TEN=3 -> RSP_ERR=1, RSP_BIN=ERR_BIN, DONE_CNT increments.
REQ-035 RSP_READY low for 5 cycles in RESP -> RSP_VALID and data stable for all 5 cycles, both READY=0, no new transfer.
REQ-036 RST=1 in CONV, then in RESP -> next cycle IDLE, RSP_VALID=0, DONE_CNT=0; a following REQ0 request completes normally.
REQ-037 256 back-to-back completions -> DONE_CNT wraps to 0.
